// File: rtl/dcache_miss_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dcache_miss_ctrl_pkg
// Shared definitions for the data-cache miss controller:
//   - miss_state_t and its state constants (IDLE, WB_REQ, WB_WAIT, PF_REQ,
//     PF_WAIT, FIN)
//   - line_off_bits(): byte-offset width of a cache line given its word count
// ----------------------------------------------------------------------------
package dcache_miss_ctrl_pkg;

    // Miss-handling FSM state encoding.
    typedef logic [2:0] miss_state_t;

    localparam miss_state_t StIdle   = 3'd0;
    localparam miss_state_t StWbReq  = 3'd1;
    localparam miss_state_t StWbWait = 3'd2;
    localparam miss_state_t StPfReq  = 3'd3;
    localparam miss_state_t StPfWait = 3'd4;
    localparam miss_state_t StFin    = 3'd5;

    // Number of low address bits that select a byte within a line of
    // 32-bit words.
    function automatic int unsigned line_off_bits(input int unsigned line_words);
        return $clog2(line_words * 4);
    endfunction

endpackage

// File: rtl/dcache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_miss_ctrl
// Sequences a data-cache miss: optional write-back of a dirty victim line,
// then a page-fault (line fill) burst, each handed to a DMA engine with a
// happen/done handshake and guarded by a wait timeout.
//
// Ports
//   cpu_clk, cpu_rst_n          clock, synchronous active-low reset
//   miss_valid / miss_ready     miss request handshake (ready only in IDLE)
//   miss_addr                   missing byte address
//   miss_victim_dirty/_addr     victim needs write-back / victim byte address
//   miss_done, miss_err         one-cycle completion / timeout-abort pulses
//   cpu_stall                   high while a miss is in flight
//   dma_write_back_*            write-back request: happen, done, addr, len
//   dma_page_fault_*            line-fill request: happen, done, addr, len
//   miss_count, wb_count        saturating completed fill / write-back counts
// ----------------------------------------------------------------------------
module dcache_miss_ctrl
    import dcache_miss_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned READ_BURST_LEN  = 8,
    parameter int unsigned WRITE_BURST_LEN = 8,
    parameter int unsigned LINE_WORDS      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,

    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_WIDTH-1:0]      miss_addr,
    input  logic                       miss_victim_dirty,
    input  logic [ADDR_WIDTH-1:0]      miss_victim_addr,
    output logic                       miss_done,
    output logic                       miss_err,
    output logic                       cpu_stall,

    output logic                       dma_write_back_happen,
    input  logic                       dma_write_back_done,
    output logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
    output logic [WRITE_BURST_LEN-1:0] dma_write_back_burst_len,

    output logic                       dma_page_fault_happen,
    input  logic                       dma_page_fault_done,
    output logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
    output logic [READ_BURST_LEN-1:0]  dma_page_fault_burst_len,

    output logic [31:0]                miss_count,
    output logic [31:0]                wb_count
);

    localparam int unsigned OffBits = line_off_bits(LINE_WORDS);
    localparam int unsigned TimerW  = $clog2(TIMEOUT_CYCLES);

    // Timer value on the last permitted WAIT cycle.
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    // Clears the byte-within-line bits of an address.
    localparam logic [ADDR_WIDTH-1:0] LineMask =
        ~ADDR_WIDTH'((64'd1 << OffBits) - 64'd1);

    localparam logic [WRITE_BURST_LEN-1:0] WbLen = WRITE_BURST_LEN'(LINE_WORDS - 1);
    localparam logic [READ_BURST_LEN-1:0]  PfLen = READ_BURST_LEN'(LINE_WORDS - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    miss_state_t                state_q, state_d;
    logic [TimerW-1:0]          timer_q, timer_d;
    logic [ADDR_WIDTH-1:0]      wb_addr_q, wb_addr_d;
    logic [ADDR_WIDTH-1:0]      pf_addr_q, pf_addr_d;
    logic [WRITE_BURST_LEN-1:0] wb_len_q, wb_len_d;
    logic [READ_BURST_LEN-1:0]  pf_len_q, pf_len_d;
    logic                       wb_happen_q, wb_happen_d;
    logic                       pf_happen_q, pf_happen_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [31:0]                miss_count_q, miss_count_d;
    logic [31:0]                wb_count_q, wb_count_d;

    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        wb_addr_d    = wb_addr_q;
        pf_addr_d    = pf_addr_q;
        wb_len_d     = wb_len_q;
        pf_len_d     = pf_len_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        err_d        = 1'b0;

        case (state_q)
            StIdle: begin
                if (miss_valid) begin
                    wb_addr_d = miss_victim_addr & LineMask;
                    pf_addr_d = miss_addr & LineMask;
                    wb_len_d  = WbLen;
                    pf_len_d  = PfLen;
                    state_d   = miss_victim_dirty ? StWbReq : StPfReq;
                end
            end
            StWbReq: state_d = StWbWait;
            StWbWait: begin
                // Done takes priority over an expiry on the same cycle.
                if (dma_write_back_done) begin
                    state_d    = StPfReq;
                    wb_count_d = sat_inc(wb_count_q);
                end else if (timer_q == TimerLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StPfReq: state_d = StPfWait;
            StPfWait: begin
                if (dma_page_fault_done) begin
                    state_d      = StFin;
                    miss_count_d = sat_inc(miss_count_q);
                end else if (timer_q == TimerLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Registered outputs decoded from the next state so they line up
        // with the state they belong to.
        wb_happen_d = (state_d == StWbReq) || (state_d == StWbWait);
        pf_happen_d = (state_d == StPfReq) || (state_d == StPfWait);
        done_d      = (state_d == StFin);
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            wb_addr_q    <= '0;
            pf_addr_q    <= '0;
            wb_len_q     <= '0;
            pf_len_q     <= '0;
            wb_happen_q  <= 1'b0;
            pf_happen_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            wb_addr_q    <= wb_addr_d;
            pf_addr_q    <= pf_addr_d;
            wb_len_q     <= wb_len_d;
            pf_len_q     <= pf_len_d;
            wb_happen_q  <= wb_happen_d;
            pf_happen_q  <= pf_happen_d;
            done_q       <= done_d;
            err_q        <= err_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign miss_ready               = (state_q == StIdle);
    assign cpu_stall                = (state_q != StIdle);
    assign miss_done                = done_q;
    assign miss_err                 = err_q;
    assign dma_write_back_happen    = wb_happen_q;
    assign dma_write_back_addr      = wb_addr_q;
    assign dma_write_back_burst_len = wb_len_q;
    assign dma_page_fault_happen    = pf_happen_q;
    assign dma_page_fault_addr      = pf_addr_q;
    assign dma_page_fault_burst_len = pf_len_q;
    assign miss_count               = miss_count_q;
    assign wb_count                 = wb_count_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcache_miss_ctrl
// Self-checking bench for dcache_miss_ctrl (TIMEOUT_CYCLES = 16, 8-word lines).
// A DMA responder answers each happen after a chosen number of WAIT cycles;
// transaction outcomes come from a table of hand-computed vectors and from a
// stage-level timing model for random transactions.
// ----------------------------------------------------------------------------
module tb_dcache_miss_ctrl;

    localparam int T = 16;
    localparam logic [31:0] LineMask = ~32'h1F;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        miss_valid, miss_ready, miss_victim_dirty;
    logic [31:0] miss_addr, miss_victim_addr;
    logic        miss_done, miss_err, cpu_stall;
    logic        dma_write_back_happen, dma_write_back_done;
    logic [31:0] dma_write_back_addr;
    logic [7:0]  dma_write_back_burst_len;
    logic        dma_page_fault_happen, dma_page_fault_done;
    logic [31:0] dma_page_fault_addr;
    logic [7:0]  dma_page_fault_burst_len;
    logic [31:0] miss_count, wb_count;

    dcache_miss_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .cpu_clk                  (cpu_clk),
        .cpu_rst_n                (cpu_rst_n),
        .miss_valid               (miss_valid),
        .miss_ready               (miss_ready),
        .miss_addr                (miss_addr),
        .miss_victim_dirty        (miss_victim_dirty),
        .miss_victim_addr         (miss_victim_addr),
        .miss_done                (miss_done),
        .miss_err                 (miss_err),
        .cpu_stall                (cpu_stall),
        .dma_write_back_happen    (dma_write_back_happen),
        .dma_write_back_done      (dma_write_back_done),
        .dma_write_back_addr      (dma_write_back_addr),
        .dma_write_back_burst_len (dma_write_back_burst_len),
        .dma_page_fault_happen    (dma_page_fault_happen),
        .dma_page_fault_done      (dma_page_fault_done),
        .dma_page_fault_addr      (dma_page_fault_addr),
        .dma_page_fault_burst_len (dma_page_fault_burst_len),
        .miss_count               (miss_count),
        .wb_count                 (wb_count)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference counter values.
    int exp_mc = 0;
    int exp_wc = 0;

    // Responder configuration: done is raised on WAIT cycle index dw_cur/dp_cur.
    int dw_cur = 0, dp_cur = 0;
    int wb_hcnt = 0, pf_hcnt = 0;
    bit noise = 1'b0;

    typedef struct {
        logic        dirty;
        logic [31:0] victim;
        logic [31:0] miss;
        int          dw;
        int          dp;
        logic [31:0] exp_wb;
        logic [31:0] exp_pf;
        bit          exp_done;
        int          exp_cyc;
        int          exp_wbc;
        int          exp_pfc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Drives the DMA done inputs for the current cycle from the observed happen lines.
    task automatic drive_dma();
        if (dma_write_back_happen) begin
            dma_write_back_done = (wb_hcnt == dw_cur + 1);
            wb_hcnt++;
        end else begin
            dma_write_back_done = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            wb_hcnt = 0;
        end
        if (dma_page_fault_happen) begin
            dma_page_fault_done = (pf_hcnt == dp_cur + 1);
            pf_hcnt++;
        end else begin
            dma_page_fault_done = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            pf_hcnt = 0;
        end
    endtask

    // Stage-level timing model: each stage is one REQ cycle plus WAIT cycles
    // up to and including the done cycle, or T WAIT cycles on timeout.
    function automatic void model(input logic dirty, input int dw, input int dp,
                                  output bit edone, output int ecyc,
                                  output int ewbc, output int epfc);
        int s;
        s = 1;
        ewbc = 0;
        epfc = 0;
        edone = 1'b0;
        if (dirty) begin
            if (dw >= T) begin
                ewbc = T + 1;
                ecyc = s + T + 1;
                return;
            end
            ewbc = dw + 2;
            s += dw + 2;
        end
        if (dp >= T) begin
            epfc = T + 1;
            ecyc = s + T + 1;
        end else begin
            epfc  = dp + 2;
            edone = 1'b1;
            ecyc  = s + dp + 2;
        end
    endfunction

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(11, 0));
        if (r <= 7) return r;
        if (r == 8) return T - 2;
        if (r == 9) return T - 1;
        if (r == 10) return T;
        return 40;
    endfunction

    task automatic run_txn(input string tag, input logic dirty, input logic [31:0] victim,
                           input logic [31:0] maddr, input int dw, input int dp,
                           input logic [31:0] ewb, input logic [31:0] epf, input bit edone,
                           input int ecyc, input int ewbc, input int epfc);
        int c, gcyc, wbn, pfn;
        bit got, addr_ok, overlap, stall_ok;
        logic gdone, gerr;
        check({tag, " ready@accept"}, miss_ready, 1'b1);
        miss_valid        = 1'b1;
        miss_victim_dirty = dirty;
        miss_victim_addr  = victim;
        miss_addr         = maddr;
        dw_cur = dw;
        dp_cur = dp;
        drive_dma();
        tick();
        // Scramble request inputs: outputs must come from captured values.
        miss_valid        = 1'b0;
        miss_victim_dirty = 1'($urandom_range(1, 0));
        miss_victim_addr  = $urandom;
        miss_addr         = $urandom;
        c = 1; got = 0; gcyc = 0; wbn = 0; pfn = 0;
        addr_ok = 1; overlap = 0; stall_ok = 1; gdone = 0; gerr = 0;
        while (!got && c <= 200) begin
            if (dma_write_back_happen) begin
                wbn++;
                if (dma_write_back_addr !== ewb || dma_write_back_burst_len !== 8'd7)
                    addr_ok = 0;
            end
            if (dma_page_fault_happen) begin
                pfn++;
                if (dma_page_fault_addr !== epf || dma_page_fault_burst_len !== 8'd7)
                    addr_ok = 0;
            end
            if (dma_write_back_happen && dma_page_fault_happen) overlap = 1;
            if (miss_done || miss_err) begin
                got = 1; gcyc = c; gdone = miss_done; gerr = miss_err;
                check({tag, " stall@end"}, cpu_stall, edone);
            end else if (!(cpu_stall === 1'b1 && miss_ready === 1'b0)) begin
                stall_ok = 0;
            end
            drive_dma();
            tick();
            c++;
        end
        check({tag, " outcome seen"}, got, 1'b1);
        check({tag, " done/err"}, {gdone, gerr}, {edone, ~edone});
        check({tag, " latency"}, gcyc, ecyc);
        check({tag, " wb happen cycles"}, wbn, ewbc);
        check({tag, " pf happen cycles"}, pfn, epfc);
        check({tag, " addr/len"}, addr_ok, 1'b1);
        check({tag, " no overlap"}, overlap, 1'b0);
        check({tag, " stall/ready busy"}, stall_ok, 1'b1);
        if (edone) exp_mc++;
        if (dirty && epfc > 0) exp_wc++;
        check({tag, " pulse width"}, {miss_done, miss_err}, 2'b00);
        check({tag, " ready after"}, miss_ready, 1'b1);
        check({tag, " miss_count"}, miss_count, exp_mc);
        check({tag, " wb_count"}, wb_count, exp_wc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " happen"}, {dma_write_back_happen, dma_page_fault_happen}, 2'b00);
        check({tag, " addrs"}, {dma_write_back_addr, dma_page_fault_addr}, 64'h0);
        check({tag, " lens"}, {dma_write_back_burst_len, dma_page_fault_burst_len}, 16'h0);
        check({tag, " pulses/stall"}, {miss_done, miss_err, cpu_stall}, 3'b000);
        check({tag, " counters"}, {miss_count, wb_count}, 64'h0);
        check({tag, " ready"}, miss_ready, 1'b1);
    endtask

    initial begin
        bit edone, flag;
        int ecyc, ewbc, epfc, dw, dp;
        logic d;
        logic [31:0] va, ma;

        // dirty victim miss dw dp exp_wb exp_pf done cyc wbc pfc
        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_1234, 0, 3,
                    32'h0, 32'h0000_1220, 1'b1, 6, 0, 5};
        vecs[1] = '{1'b1, 32'h0000_8004, 32'h0000_40FF, 0, 0,
                    32'h0000_8000, 32'h0000_40E0, 1'b1, 5, 2, 2};
        vecs[2] = '{1'b0, 32'h1111_1111, 32'hFFFF_FFFF, 0, 0,
                    32'h0, 32'hFFFF_FFE0, 1'b1, 3, 0, 2};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_2000, 0, 100,
                    32'h0, 32'h0000_2000, 1'b0, 18, 0, 17};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_3010, 0, 15,
                    32'h0, 32'h0000_3000, 1'b1, 18, 0, 17};
        vecs[5] = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 100, 0,
                    32'hDEAD_BEE0, 32'h0000_0000, 1'b0, 18, 17, 0};
        vecs[6] = '{1'b1, 32'h0000_003F, 32'h1000_0020, 2, 100,
                    32'h0000_0020, 32'h1000_0020, 1'b0, 22, 4, 17};
        vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_001F, 15, 15,
                    32'h7FFF_FFE0, 32'h8000_0000, 1'b1, 35, 17, 17};

        cpu_rst_n = 1'b0;
        miss_valid = 1'b0; miss_victim_dirty = 1'b0;
        miss_addr = '0; miss_victim_addr = '0;
        dma_write_back_done = 1'b0; dma_page_fault_done = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        cpu_rst_n = 1'b1;
        tick();
        check("ready after release", miss_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].dirty, vecs[i].victim, vecs[i].miss,
                    vecs[i].dw, vecs[i].dp, vecs[i].exp_wb, vecs[i].exp_pf,
                    vecs[i].exp_done, vecs[i].exp_cyc, vecs[i].exp_wbc, vecs[i].exp_pfc);
        end

        // Spurious done inputs while idle are ignored.
        flag = 1;
        dma_write_back_done = 1'b1;
        dma_page_fault_done = 1'b1;
        repeat (3) begin
            tick();
            if (cpu_stall || miss_done || miss_err) flag = 0;
        end
        dma_write_back_done = 1'b0;
        dma_page_fault_done = 1'b0;
        check("idle done ignored", flag, 1'b1);
        check("idle done counters", {miss_count, wb_count}, {exp_mc[31:0], exp_wc[31:0]});

        // miss_valid held high: the second request waits until after FIN.
        miss_valid = 1'b1; miss_victim_dirty = 1'b0; miss_addr = 32'h0000_2044;
        dw_cur = 0; dp_cur = 0;
        check("hold ready c0", miss_ready, 1'b1);
        flag = 1;
        for (int c = 1; c <= 3; c++) begin
            drive_dma();
            tick();
            if (miss_ready !== 1'b0) flag = 0;
        end
        check("hold ready low while busy", flag, 1'b1);
        check("hold done at FIN", miss_done, 1'b1);
        drive_dma();
        tick();
        check("hold ready after FIN", miss_ready, 1'b1);
        drive_dma();
        tick();
        miss_valid = 1'b0;
        check("hold second accepted", {cpu_stall, dma_page_fault_happen}, 2'b11);
        check("hold second addr", dma_page_fault_addr, 32'h0000_2040);
        flag = 0;
        for (int c = 0; c < 20 && !flag; c++) begin
            drive_dma();
            tick();
            if (miss_done) flag = 1;
        end
        check("hold second done", flag, 1'b1);
        drive_dma();
        tick();
        exp_mc += 2;
        check("hold miss_count", miss_count, exp_mc);

        // Reset in the middle of PF_WAIT.
        miss_valid = 1'b1; miss_victim_dirty = 1'b0; miss_addr = 32'h5555_5555;
        dp_cur = 1000;
        drive_dma();
        tick();
        miss_valid = 1'b0;
        repeat (3) begin
            drive_dma();
            tick();
        end
        check("pf_wait before reset", {cpu_stall, dma_page_fault_happen}, 2'b11);
        cpu_rst_n = 1'b0;
        dma_page_fault_done = 1'b0;
        tick();
        check_all_zero("mid reset");
        cpu_rst_n = 1'b1;
        tick();
        check("ready after mid reset", miss_ready, 1'b1);
        exp_mc = 0;
        exp_wc = 0;

        // Random transactions with done noise outside the active stages.
        noise = 1'b1;
        for (int k = 0; k < 30; k++) begin
            d  = 1'($urandom_range(1, 0));
            dw = pick_delay();
            dp = pick_delay();
            va = $urandom;
            ma = $urandom;
            model(d, dw, dp, edone, ecyc, ewbc, epfc);
            run_txn($sformatf("rand%0d", k), d, va, ma, dw, dp, va & LineMask, ma & LineMask,
                    edone, ecyc, ewbc, epfc);
            repeat ($urandom_range(3, 0)) begin
                drive_dma();
                tick();
            end
        end
        noise = 1'b0;
        dma_write_back_done = 1'b0;
        dma_page_fault_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter READ_BURST_LEN, default 8, width of the page-fault burst-length field.
REQ-003 SHALL have parameter WRITE_BURST_LEN, default 8, width of the write-back burst-length field.
REQ-004 SHALL have parameter LINE_WORDS, default 8, 32-bit words per cache line, power of two, 2..256.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait cycles before abort, at least 2.
REQ-006 SHALL have port cpu_clk, input, 1, sole clock.
REQ-007 SHALL have port cpu_rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-008 SHALL have port miss_valid, input, 1, cache miss request.
REQ-009 SHALL have port miss_ready, output, 1, request accepted when high with miss_valid.
REQ-010 SHALL have port miss_addr, input, ADDR_WIDTH, missing byte address.
REQ-011 SHALL have port miss_victim_dirty, input, 1, victim line needs write-back.
REQ-012 SHALL have port miss_victim_addr, input, ADDR_WIDTH, victim byte address.
REQ-013 SHALL have port miss_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port miss_err, output, 1, one-cycle timeout-abort pulse.
REQ-015 SHALL have port cpu_stall, output, 1, high while a miss is in flight.
REQ-016 SHALL have ports dma_write_back_happen (out, 1), dma_write_back_done (in, 1), dma_write_back_addr (out, ADDR_WIDTH), dma_write_back_burst_len (out, WRITE_BURST_LEN).
REQ-017 SHALL have ports dma_page_fault_happen (out, 1), dma_page_fault_done (in, 1), dma_page_fault_addr (out, ADDR_WIDTH), dma_page_fault_burst_len (out, READ_BURST_LEN).
REQ-018 SHALL have ports miss_count and wb_count, output, 32 each, saturating event counters.

Function
REQ-019 SHALL implement FSM states IDLE, WB_REQ, WB_WAIT, PF_REQ, PF_WAIT, FIN.
REQ-020 SHALL drive miss_ready=1 only in IDLE; accept a request on miss_valid&&miss_ready, capturing both addresses and the dirty flag.
REQ-021 SHALL go IDLE->WB_REQ on accept when dirty, else IDLE->PF_REQ.
REQ-022 SHALL align captured addresses by clearing the low log2(LINE_WORDS*4) bits.
REQ-023 SHALL drive both burst_len outputs to LINE_WORDS-1 (8 -> 7), zero-extended or truncated to field width.
REQ-024 SHALL, in WB_REQ, assert dma_write_back_happen registered with stable addr/len and advance to WB_WAIT next cycle; happen stays high through WB_WAIT.
REQ-025 SHALL, in WB_WAIT on dma_write_back_done=1, deassert happen next cycle, increment wb_count, enter PF_REQ.
REQ-026 SHALL mirror REQ-024/025 for PF_REQ/PF_WAIT with the page-fault ports, incrementing miss_count and entering FIN.
REQ-027 SHALL, in FIN, pulse miss_done for one cycle and return to IDLE; minimum accept-to-miss_done latency is 3 cycles clean, 5 dirty, with zero-latency done.
REQ-028 SHALL ignore done inputs outside the matching WAIT state.
REQ-029 SHALL count cycles in each WAIT state; at TIMEOUT_CYCLES without done, drop happen, pulse miss_err, return to IDLE with no miss_done and no counter increment.
REQ-030 SHALL let done win when done and timeout expiry coincide.
REQ-031 SHALL drive cpu_stall=1 in every state except IDLE.
REQ-032 SHALL saturate counters at 32'hFFFF_FFFF.
REQ-033 SHALL keep address outputs stable from REQ state until happen drops.

Reset
REQ-034 SHALL, on cpu_rst_n=0 at a cpu_clk edge, enter IDLE, clear all happen, addr, len, pulse and counter outputs to 0, even mid-transaction; miss_ready=1 the first cycle after reset release.

Structure
REQ-035 SHALL place the FSM state enum and the line-offset width function in the shared bus package.
REQ-036 SHALL be one flat module; the timeout counter is inline, no sub-module.

Verification
REQ-037 Clean miss 0x0000_1234, page-fault done 4 cycles after happen -> fault addr 0x0000_1220, len 7, miss_done once, miss_count=1, wb_count=0.
REQ-038 Dirty miss, victim 0x0000_8004 -> write-back addr 0x0000_8000 completes before dma_page_fault_happen rises; wb_count=1, miss_count=1.
REQ-039 TIMEOUT_CYCLES=16, no done -> happen drops after 16 WAIT cycles, miss_err pulse, no miss_done, miss_ready=1 next cycle.
REQ-040 miss_valid held high throughout a busy transaction -> second request accepted only after FIN; spurious done in IDLE ignored.
REQ-041 cpu_rst_n low during PF_WAIT -> all outputs 0 next cycle, IDLE, counters 0.
REQ-042 Done on the exact timeout cycle -> miss_done, no miss_err.
